// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: state encoding,
// default register-address width and the hard-wired zero register.
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: stage flags in, register enables/flushes out.
interface pipeline_hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  logic ex_memread, branch_taken, mem_access, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_error;
  logic [15:0] stall_cycles, flush_cycles;

  modport master (
    output id_rs, id_rt, ex_rt, ex_memread, branch_taken, mem_access, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, mem_error, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_memread, branch_taken, mem_access, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, mem_error, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: EX holds a load whose rt feeds a source of the ID instruction.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_memread,
  output logic                  load_use
);
  assign load_use = ex_memread && (ex_rt != REG_ADDR_W'(ZERO_REG)) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Define HAZARD_PERF_COUNTERS_EN
// to build the stall/flush cycle counters; otherwise they read as zero.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 15
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_PENALTY - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [2:0] flushCnt, savedCnt;
  logic [7:0] waitCnt;
  logic       errQ;
  logic       loadUse, memStall, timeout;
  logic [4:0] en;  // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic       ifFl, idFl;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) uDetect (
    .ex_rt      (hz.ex_rt),
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .ex_memread (hz.ex_memread),
    .load_use   (loadUse)
  );

  assign memStall = hz.mem_access && !hz.mem_ready;
  assign timeout  = (state == MEM_WAIT) && !hz.mem_ready && (waitCnt == WAIT_LAST);

  // Zero-latency outputs; reset forces the free-running pipeline pattern.
  always_comb begin
    en   = '1;
    ifFl = 1'b0;
    idFl = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (memStall) en = '0;
          else if (hz.branch_taken) begin
            ifFl = 1'b1;
            idFl = 1'b1;
          end else if (loadUse) begin
            en[4:3] = 2'b00;
            idFl    = 1'b1;
          end
        end
        FLUSH: begin
          if (memStall) en = '0;
          else ifFl = 1'b1;
        end
        MEM_WAIT: if (!hz.mem_ready && !timeout) en = '0;
        default: ;
      endcase
    end
  end

  assign {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en} = en;
  assign hz.if_id_flush = ifFl;
  assign hz.id_ex_flush = idFl;
  assign hz.mem_error   = errQ || (timeout && !reset);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      flushCnt <= '0;
      savedCnt <= '0;
      waitCnt  <= '0;
      errQ     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state    <= MEM_WAIT;
            waitCnt  <= '0;
            savedCnt <= hz.branch_taken ? FLUSH_LOAD : 3'd0;
          end else if (hz.branch_taken && (BRANCH_PENALTY > 1)) begin
            state    <= FLUSH;
            flushCnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          // A stall parks the remaining flush count until memory answers.
          if (memStall) begin
            state    <= MEM_WAIT;
            waitCnt  <= '0;
            savedCnt <= hz.branch_taken ? FLUSH_LOAD : flushCnt;
          end else if (hz.branch_taken) flushCnt <= FLUSH_LOAD;
          else if (flushCnt <= 3'd1) state <= RUN;
          else flushCnt <= flushCnt - 3'd1;
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            state    <= (savedCnt != 3'd0) ? FLUSH : RUN;
            flushCnt <= savedCnt;
            savedCnt <= '0;
          end else if (timeout) begin
            state    <= RUN;
            errQ     <= 1'b1;
            savedCnt <= '0;
          end else waitCnt <= waitCnt + 8'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [15:0] stallQ, flushQ;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallQ <= '0;
      flushQ <= '0;
    end else begin
      if (!en[4] && (stallQ != 16'hFFFF)) stallQ <= stallQ + 16'd1;
      if (ifFl && (flushQ != 16'hFFFF))   flushQ <= flushQ + 16'd1;
    end
  end
  assign hz.stall_cycles = stallQ;
  assign hz.flush_cycles = flushQ;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table plus
// multi-cycle sequences for branch flush, memory wait, timeout and async reset.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nErr = 0;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .BRANCH_PENALTY(2), .MEM_TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // want = {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  typedef struct {
    logic [4:0] rs, rt, exRt;
    logic       mr, br, acc, rdy;
    logic [6:0] want;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] outs();
    return {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
            hz.if_id_flush, hz.id_ex_flush};
  endfunction

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exRt,
                       input logic mr, input logic br, input logic acc, input logic rdy);
    hz.id_rs = rs; hz.id_rt = rt; hz.ex_rt = exRt;
    hz.ex_memread = mr; hz.branch_taken = br; hz.mem_access = acc; hz.mem_ready = rdy;
  endtask

  task automatic chk(input string nm, input logic [6:0] want, input logic wantErr);
    nChecks++;
    if (outs() !== want || hz.mem_error !== wantErr) begin
      nErr++;
      $display("FAIL %s: got ctl=%b err=%b, expected ctl=%b err=%b",
               nm, outs(), hz.mem_error, want, wantErr);
    end
  endtask

  task automatic chkCnt(input string nm, input logic [15:0] act, input logic [15:0] want);
    nChecks++;
    if (act !== want) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Check at the falling edge, then move to just after the next rising edge.
  task automatic cyc(input string nm, input logic [6:0] want, input logic wantErr);
    @(negedge clk);
    chk(nm, want, wantErr);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b11111_00}; // idle
    vecs[1]  = '{5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 7'b00111_01}; // lu via rs
    vecs[2]  = '{5'd2, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 7'b00111_01}; // lu via rt
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b11111_00}; // $zero
    vecs[4]  = '{5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 7'b11111_00}; // not a load
    vecs[5]  = '{5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 7'b11111_00}; // no match
    vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b11111_11}; // branch
    vecs[7]  = '{5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 7'b11111_11}; // branch > lu
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b00000_00}; // mem stall
    vecs[9]  = '{5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 7'b00000_00}; // stall wins
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b11111_00}; // ready access
    vecs[11] = '{5'd2, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 7'b00111_01}; // ready + lu

    // Reset overrides any hazard inputs.
    setIn(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    chk("reset outputs", 7'b11111_00, 1'b0);
    chkCnt("reset stall_cycles", hz.stall_cycles, 16'd0);
    chkCnt("reset flush_cycles", hz.flush_cycles, 16'd0);
    #10;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      doReset();
      setIn(vecs[i].rs, vecs[i].rt, vecs[i].exRt, vecs[i].mr, vecs[i].br, vecs[i].acc, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].want, 1'b0);
    end

    // Load-use: one bubble, then free flow; $zero destination never stalls.
    doReset();
    setIn(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu bubble", 7'b00111_01, 1'b0);
    setIn(5'd8, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu release", 7'b11111_00, 1'b0);
    setIn(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu zero reg", 7'b11111_00, 1'b0);

    // Branch with penalty 2.
    doReset();
    setIn(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("br cycle0", 7'b11111_11, 1'b0);
    hz.branch_taken = 1'b0;
    cyc("br cycle1", 7'b11111_10, 1'b0);
    @(negedge clk);
    chk("br cycle2", 7'b11111_00, 1'b0);
    chkCnt("br flush_cycles", hz.flush_cycles, PERF ? 16'd2 : 16'd0);
    @(posedge clk);
    #1;

    // Memory wait for three cycles.
    doReset();
    setIn(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc($sformatf("mw stall%0d", i), 7'b00000_00, 1'b0);
    hz.mem_ready = 1'b1;
    cyc("mw ready", 7'b11111_00, 1'b0);
    setIn(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mw after", 7'b11111_00, 1'b0);
    chkCnt("mw stall_cycles", hz.stall_cycles, PERF ? 16'd3 : 16'd0);
    @(posedge clk);
    #1;

    // Branch + load-use + memory stall together.
    doReset();
    setIn(5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("sim stall", 7'b00000_00, 1'b0);
    hz.branch_taken = 1'b0;
    cyc("sim wait", 7'b00000_00, 1'b0);
    hz.mem_ready = 1'b1;
    cyc("sim ready", 7'b11111_00, 1'b0);
    hz.mem_access = 1'b0;
    hz.mem_ready = 1'b0;
    cyc("sim flush no lu", 7'b11111_10, 1'b0);
    hz.ex_memread = 1'b0;
    cyc("sim run", 7'b11111_00, 1'b0);

    // Timeout: 15 stalled cycles, one retire cycle, then sticky error in RUN.
    doReset();
    setIn(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cyc($sformatf("to stall%0d", i), 7'b00000_00, 1'b0);
    cyc("to retire", 7'b11111_00, 1'b1);
    setIn(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("to run branch", 7'b11111_11, 1'b1);
    hz.branch_taken = 1'b0;
    cyc("to flush", 7'b11111_10, 1'b1);
    cyc("to sticky", 7'b11111_00, 1'b1);

    // Async reset in the middle of MEM_WAIT.
    doReset();
    setIn(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("ar stall", 7'b00000_00, 1'b0);
    cyc("ar wait", 7'b00000_00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar immediate", 7'b11111_00, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    setIn(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ar run", 7'b11111_00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Squashes wrong-path instructions after a taken branch or jump.
- Freezes the whole pipeline while a data-memory access is outstanding.
- Drives the PC enable plus the enable and flush of every pipeline register. It sits beside the datapath and takes its flags from the ID, EX and MEM stages.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- BRANCH_PENALTY, 2, number of cycles IF/ID is flushed after a taken branch or jump. Legal range 1..7.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT before the controller aborts. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- ex_rt  in  REG_ADDR_W  destination rt of the instruction in EX.
- ex_memread  in  1  MemRead of the instruction in EX.
- branch_taken  in  1  branchAndZero_flag or Jump, resolved in EX.
- mem_access  in  1  MemRead or MemWrite of the instruction in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_flush  out  1  clear the control bits of ID/EX, inserting a bubble.
- mem_error  out  1  sticky flag: memory access timed out.
- stall_cycles  out  16  performance counter (optional feature).
- flush_cycles  out  16  performance counter (optional feature).

Behaviour:
- Reset (async):
  - state is RUN; flush_cnt and wait_cnt are 0; mem_error is 0; counters are 0.
  - While reset is high, all enables are 1 and both flushes are 0.
- Outputs are combinational from the current state and current inputs (zero latency). State updates on the clk rising edge.
- Hazard term: load_use = ex_memread and ex_rt != 0 and (ex_rt == id_rs or ex_rt == id_rt).
- Priority in every state: memory wait > branch flush > load-use.
- RUN:
  - If mem_access and not mem_ready:
    - All five enables are 0 and both flushes are 0.
    - Next state is MEM_WAIT; wait_cnt is cleared to 0.
    - A branch_taken arriving in the same cycle is latched as pend_flush and serviced after the wait.
  - Else if branch_taken:
    - All enables are 1; if_id_flush=1 and id_ex_flush=1.
    - If BRANCH_PENALTY > 1, the next state is FLUSH and flush_cnt is loaded with BRANCH_PENALTY-1; otherwise the state stays RUN.
  - Else if load_use:
    - pc_en=0, if_id_en=0, id_ex_flush=1; the other enables are 1.
    - The state stays RUN. Exactly one bubble is inserted per load-use.
  - Else all enables are 1 and both flushes are 0.
- FLUSH:
  - All enables are 1; if_id_flush=1; id_ex_flush=0.
  - flush_cnt decrements each cycle; when flush_cnt==1, the next state is RUN.
  - load_use is ignored, because ID holds a flushed NOP.
  - A new branch_taken reloads flush_cnt.
  - If a memory stall occurs, the controller goes to MEM_WAIT and saves the remaining flush_cnt.
- MEM_WAIT:
  - While mem_ready is 0, all enables are 0 and wait_cnt increments.
  - On mem_ready=1, all enables are 1 that same cycle. The next state is FLUSH if a flush is pending or saved, otherwise RUN.
  - On timeout, when wait_cnt reaches MEM_TIMEOUT-1 without mem_ready:
    - mem_error is set and stays set until reset.
    - All enables are 1 for one cycle so the access retires, and the next state is RUN.
- Reset mid-stall returns to RUN immediately and asynchronously.
- state is encoded in 2 bits (RUN=0, FLUSH=1, MEM_WAIT=2). The unused code 3 recovers to RUN.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- When defined:
  - stall_cycles increments in every cycle where pc_en=0.
  - flush_cycles increments in every cycle where if_id_flush=1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- When undefined, both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - the state encoding constants RUN, FLUSH and MEM_WAIT;
  - the REG_ADDR_W default;
  - the zero-register constant 0.
- Natural sub-module: hazard_detect, the purely combinational load_use comparator (ex_rt, id_rs, id_rt, ex_memread to load_use). It is instantiated once.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, for one cycle.
  - Expect pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle, then all enables 1.
  - Repeat with ex_rt=0 and expect no stall.
- Branch with BRANCH_PENALTY=2: branch_taken pulse.
  - Cycle 0: if_id_flush=1, id_ex_flush=1.
  - Cycle 1: if_id_flush=1 only.
  - Cycle 2: both flushes 0; flush_cycles=2.
- Memory wait: mem_access=1 with mem_ready low for 3 cycles, then high.
  - All enables 0 for 3 cycles, then 1; stall_cycles=3; mem_error=0.
- Simultaneous events: branch_taken, load_use and a memory stall in the same cycle.
  - MEM_WAIT wins.
  - After mem_ready, FLUSH runs for BRANCH_PENALTY-1 cycles.
  - No load-use bubble is inserted.
- Timeout with MEM_TIMEOUT=15: mem_ready held at 0.
  - After 15 stalled cycles, mem_error=1, one cycle with enables 1, then state RUN.
  - mem_error stays 1 until reset.
- Async reset asserted mid-MEM_WAIT: outputs return to reset values immediately; state is RUN after reset is released.
